// File: rtl/serial_and_collector.sv
// Bit-serial AND collector: forms a AND b per beat via a 2:1 mux, packs the
// results into a word with all/any/popcount reductions, and hands it downstream.
module serial_and_collector #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic             up_a,
    input  logic             up_b,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CNT_W-1:0] out_len,
    output logic             out_all,
    output logic             out_any,
    output logic [CNT_W-1:0] out_pop,
    output logic             out_trunc
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  word;
    logic [CNT_W-1:0]  pop;
    logic              all_r;
    logic              any_r;

    logic              accept;
    logic              close;
    logic              rbit;
    logic [WIDTH-1:0]  word_nx;

    function automatic logic and_mux(input logic sel, input logic d1);
        return sel ? d1 : 1'b0;
    endfunction

    assign rbit    = and_mux(up_a, up_b);
    assign accept  = up_valid && up_ready;
    assign close   = up_last || (cnt == CNT_W'(WIDTH - 1));
    assign word_nx = word | (WIDTH'(rbit) << cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        up_ready   = 1'b0;
        down_valid = 1'b0;
        case (state)
            COLLECT: begin
                up_ready = 1'b1;
                if (up_valid && close) state_nx = HOLD;
            end
            HOLD: begin
                down_valid = 1'b1;
                if (down_ready) state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    // Accumulators restart as soon as a packet closes; HOLD blocks new beats
    // until the result is taken, so the cleared state is what COLLECT resumes with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            word      <= '0;
            pop       <= '0;
            all_r     <= 1'b1;
            any_r     <= 1'b0;
            out_word  <= '0;
            out_len   <= '0;
            out_all   <= 1'b0;
            out_any   <= 1'b0;
            out_pop   <= '0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            if (close) begin
                out_word  <= word_nx;
                out_len   <= cnt + CNT_W'(1);
                out_pop   <= pop + CNT_W'(rbit);
                out_all   <= all_r & rbit;
                out_any   <= any_r | rbit;
                out_trunc <= !up_last;
                cnt       <= '0;
                word      <= '0;
                pop       <= '0;
                all_r     <= 1'b1;
                any_r     <= 1'b0;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                word  <= word_nx;
                pop   <= pop + CNT_W'(rbit);
                all_r <= all_r & rbit;
                any_r <= any_r | rbit;
            end
        end
    end

endmodule

// File: tb/tb_serial_and_collector.sv
// Directed bench for serial_and_collector (WIDTH = 8) with immediate-assertion checks.
module tb_serial_and_collector;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             up_valid;
    logic             up_ready;
    logic             up_a;
    logic             up_b;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] out_word;
    logic [CNT_W-1:0] out_len;
    logic             out_all;
    logic             out_any;
    logic [CNT_W-1:0] out_pop;
    logic             out_trunc;

    int total = 0;
    int bad   = 0;

    serial_and_collector #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_a       (up_a),
        .up_b       (up_b),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .out_word   (out_word),
        .out_len    (out_len),
        .out_all    (out_all),
        .out_any    (out_any),
        .out_pop    (out_pop),
        .out_trunc  (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and keep it until the collector takes it.
    task automatic beat(input logic a, input logic b, input logic last);
        int n;
        n = 0;
        up_a = a; up_b = b; up_last = last; up_valid = 1'b1;
        while (!up_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("beat_wait_ready", {31'd0, up_ready}, 32'd1);
        @(posedge clk); #1;
        up_valid = 1'b0; up_a = 1'b0; up_b = 1'b0; up_last = 1'b0;
    endtask

    // Check the held result, then take it with a single down_ready pulse.
    task automatic pkt(input string tag, input logic [7:0] w, input int len,
                       input logic all, input logic any, input int pop, input logic trunc);
        chk({tag, "_valid"}, {31'd0, down_valid}, 32'd1);
        chk({tag, "_word"},  {24'd0, out_word}, {24'd0, w});
        chk({tag, "_len"},   32'(out_len), 32'(len));
        chk({tag, "_all"},   {31'd0, out_all}, {31'd0, all});
        chk({tag, "_any"},   {31'd0, out_any}, {31'd0, any});
        chk({tag, "_pop"},   32'(out_pop), 32'(pop));
        chk({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, trunc});
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        chk({tag, "_drained"}, {31'd0, down_valid}, 32'd0);
        chk({tag, "_ready"},   {31'd0, up_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] bseq;
        rst = 1'b1; up_valid = 1'b0; up_a = 1'b0; up_b = 1'b0; up_last = 1'b0;
        down_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_down_valid", {31'd0, down_valid}, 32'd0);
        chk("rst_word", {24'd0, out_word}, 32'd0);
        chk("rst_len", 32'(out_len), 32'd0);
        chk("rst_flags", {28'd0, out_all, out_any, out_trunc, 1'b0}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_up_ready", {31'd0, up_ready}, 32'd1);

        // truth table
        beat(1'b0, 1'b0, 1'b1); pkt("tt00", 8'h00, 1, 1'b0, 1'b0, 0, 1'b0);
        beat(1'b0, 1'b1, 1'b1); pkt("tt01", 8'h00, 1, 1'b0, 1'b0, 0, 1'b0);
        beat(1'b1, 1'b0, 1'b1); pkt("tt10", 8'h00, 1, 1'b0, 1'b0, 0, 1'b0);
        beat(1'b1, 1'b1, 1'b1); pkt("tt11", 8'h01, 1, 1'b1, 1'b1, 1, 1'b0);

        // 5-beat packet, b = 1,0,1,1,0
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        chk("p5_not_yet", {31'd0, down_valid}, 32'd0);
        beat(1'b1, 1'b0, 1'b1);
        pkt("p5", 8'h0D, 5, 1'b0, 1'b1, 3, 1'b0);

        // 10 beats: truncation at 8, then a 2-beat remainder
        for (int i = 0; i < 7; i++) beat(1'b1, 1'b1, 1'b0);
        chk("p10_pre_trunc", {31'd0, down_valid}, 32'd0);
        beat(1'b1, 1'b1, 1'b0);
        pkt("trunc", 8'hFF, 8, 1'b1, 1'b1, 8, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        pkt("rem", 8'h03, 2, 1'b1, 1'b1, 2, 1'b0);

        // backpressure with upstream pushing throughout
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        up_a = 1'b1; up_b = 1'b1; up_last = 1'b1; up_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_up_ready", {31'd0, up_ready}, 32'd0);
            chk("bp_valid", {31'd0, down_valid}, 32'd1);
            chk("bp_word", {24'd0, out_word}, 32'h01);
            chk("bp_len", 32'(out_len), 32'd2);
        end
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        chk("bp_xfer_valid", {31'd0, down_valid}, 32'd0);
        chk("bp_xfer_ready", {31'd0, up_ready}, 32'd1);
        @(posedge clk); #1;
        up_valid = 1'b0; up_last = 1'b0;
        pkt("bp_next", 8'h01, 1, 1'b1, 1'b1, 1, 1'b0);

        // exactly 8 beats with up_last on the 8th
        bseq = 8'h55;
        for (int i = 0; i < 8; i++) beat(1'b1, bseq[i], (i == 7));
        pkt("full8", 8'h55, 8, 1'b0, 1'b1, 4, 1'b0);

        // reset mid-packet
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, down_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        pkt("after_rst1", 8'h03, 2, 1'b1, 1'b1, 2, 1'b0);

        // reset while holding a result
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        chk("hold_before_rst", {31'd0, down_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_hold_valid", {31'd0, down_valid}, 32'd0);
        chk("rst_hold_word", {24'd0, out_word}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        pkt("after_rst2", 8'h03, 2, 1'b1, 1'b1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
